// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo write/read-side port arbiters.
// Holds the default data width, the arbiter state encoding and the index-width helper.
package fifo_pkg;

  localparam int FIFO_DW = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set req bit after 'last', wrapping, with 'last' itself checked last.
// Purely combinational, zero latency; vld=0 when no request is set.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld && req[i] && (i == (int'(last) + k) % NREQ)) begin
          idx = IW'(i);
          vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo write port between NREQ producers, up to BURST words per grant.
// Zero latency: ack/winc are combinational; wfull stalls the grant without releasing it, nothing is lost.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter  int DW    = FIFO_DW,
  parameter  int NREQ  = 2,
  parameter  int BURST = 4,
  localparam int IW    = idx_width(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]  ack,
  input  logic             wfull,
  output logic             winc,
  output logic [DW-1:0]    wdata,
  output logic [IW-1:0]    owner,
  output logic             busy,
  output logic [15:0]      xfer_cnt
);

  localparam int BW = idx_width(BURST);

  arb_state_t   state;
  logic [IW-1:0] last;
  logic [BW-1:0] beat;

  logic          own_req;
  logic          xfer;
  logic          burst_end;
  logic          rel;
  logic [IW-1:0] pick_last;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;

  always_comb begin
    own_req = 1'b0;
    wdata   = '0;
    ack     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) begin
        own_req = req[i];
        if (state == ST_GRANT) wdata = data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = xfer && (owner == IW'(i));
    end
  end

  assign xfer      = (state == ST_GRANT) && own_req && !wfull;
  assign winc      = xfer;
  assign busy      = (state == ST_GRANT);
  assign burst_end = (beat == BW'(BURST - 1));
  // A dropped request is a legal abort and releases the grant even under wfull.
  assign rel       = (xfer && burst_end) || !own_req;

  // On release the outgoing owner becomes the new pointer, so it is ranked last.
  assign pick_last = (state == ST_GRANT) ? owner : last;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .last (pick_last),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last     <= IW'(NREQ - 1);
      beat     <= '0;
      xfer_cnt <= '0;
    end else begin
      if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            state <= ST_GRANT;
            owner <= pick_idx;
            beat  <= '0;
          end
        end
        ST_GRANT: begin
          if (rel) begin
            last <= owner;
            beat <= '0;
            if (pick_vld) owner <= pick_idx;
            else          state <= ST_IDLE;
          end else if (xfer) begin
            beat <= beat + BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a transaction-level model.
// Producers obey the hold-until-ack rule using the model's expected ack.
module tb_fifo_wr_arb;

  localparam int DW    = 16;
  localparam int NREQ  = 2;
  localparam int BURST = 4;
  localparam int IW    = 1;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req   = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic [NREQ-1:0]   ack;
  logic              wfull = 1'b0;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic [IW-1:0]     owner;
  logic              busy;
  logic [15:0]       xfer_cnt;

  always #5 clk = ~clk;

  fifo_wr_arb #(.DW(DW), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .owner    (owner),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: who holds the grant, words taken in this grant, round-robin pointer, total words.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = NREQ - 1;
  int m_cnt   = 0;
  int m_xfer  = 0;
  bit m_valid = 1'b0;

  bit            p_req  [NREQ];
  int            p_left [NREQ];
  logic [DW-1:0] p_dat  [NREQ];
  logic [DW-1:0] p_next [NREQ];

  int            alog[$];
  logic [DW-1:0] wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mpick(input logic [NREQ-1:0] r, input int l);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(l + k) % NREQ]) return (l + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit anyp();
    bit a = 1'b0;
    for (int i = 0; i < NREQ; i++) a |= p_req[i];
    return a;
  endfunction

  task automatic load(input int i, input int n, input logic [DW-1:0] first);
    p_req[i]  = 1'b1;
    p_left[i] = n;
    p_dat[i]  = first;
    p_next[i] = first + 16'd1;
  endtask

  task automatic step(input logic wf);
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] eack;
    logic [DW-1:0]   ewd;
    bit ex, rv;
    int p, got;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req[i] = p_req[i];
      data[i*DW +: DW] = p_dat[i];
    end
    wfull = wf;
    #1;
    r  = req;
    rv = rst_n;
    ex = m_busy && r[m_owner] && !wf;
    eack = '0;
    ewd  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (m_busy && i == m_owner) begin
        eack[i] = ex;
        ewd     = p_dat[i];
      end
    end
    if (m_valid) begin
      chk("winc", winc, ex);
      chk("ack", ack, eack);
      chk("wdata", wdata, ewd);
      chk("busy", busy, m_busy);
      if (m_busy) chk("owner", owner, m_owner);
      chk("xfer_cnt", xfer_cnt, m_xfer);
    end
    got = -1;
    for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) got = i;
    alog.push_back((winc === 1'b1) ? got : -1);
    if (winc === 1'b1) wlog.push_back(wdata);
    @(posedge clk);
    #1;
    if (!rv) begin
      m_busy = 1'b0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0; m_xfer = 0;
    end else begin
      if (ex) m_xfer = (m_xfer + 1) % 65536;
      if (!m_busy) begin
        p = mpick(r, m_last);
        if (p >= 0) begin m_busy = 1'b1; m_owner = p; m_cnt = 0; end
      end else begin
        if (ex) m_cnt++;
        if ((ex && m_cnt == BURST) || !r[m_owner]) begin
          m_last = m_owner;
          p = mpick(r, m_owner);
          if (p >= 0) begin m_owner = p; m_cnt = 0; end
          else m_busy = 1'b0;
        end
      end
    end
    m_valid = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (eack[i]) begin
        p_left[i]--;
        if (p_left[i] > 0) begin
          p_dat[i]  = p_next[i];
          p_next[i] = p_next[i] + 16'd1;
        end else begin
          p_req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    bit done;
    while ((m_busy || anyp()) && n < max) begin
      step(1'b0);
      n++;
    end
    done = !(m_busy || anyp());
    chk("drain_done", done, 1);
  endtask

  initial begin
    int base, n;
    int exp_ab[8];
    for (int i = 0; i < NREQ; i++) begin
      p_req[i] = 1'b0; p_left[i] = 0; p_dat[i] = '0; p_next[i] = '0;
    end

    // Reset held with both producers requesting.
    rst_n = 1'b0;
    load(0, 12, 16'h0A00);
    load(1, 12, 16'h0B00);
    step(1'b0);
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    chk("first_owner", owner, 0);
    chk("first_busy", busy, 1);

    // Both streaming: 4 words each, alternating, no idle gap.
    alog.delete();
    repeat (24) step(1'b0);
    for (int k = 0; k < 24; k++) chk($sformatf("rr_seq%0d", k), alog[k], (k / 4) % 2);
    drain(20);

    // Single producer, ten words back to back.
    base = m_xfer;
    load(0, 10, 16'h0001);
    alog.delete(); wlog.delete();
    repeat (11) step(1'b0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("single_ack%0d", k), alog[k+1], 0);
      chk($sformatf("single_dat%0d", k), wlog[k], k + 1);
    end
    chk("single_cnt", xfer_cnt, (base + 10) % 65536);
    drain(10);

    // wfull for 5 clocks during beat 2 of producer 1.
    load(1, 4, 16'h0100);
    alog.delete(); wlog.delete();
    repeat (3) step(1'b0);
    repeat (5) step(1'b1);
    repeat (3) step(1'b0);
    for (int k = 3; k < 8; k++) chk($sformatf("full_stall%0d", k), alog[k], -1);
    chk("full_words", wlog.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("full_dat%0d", k), wlog[k], 16'h0100 + k);
    drain(10);

    // Producer 0 aborts after 2 words; producer 1 takes over for a full burst.
    load(0, 2, 16'h0200);
    load(1, 4, 16'h0300);
    alog.delete(); wlog.delete();
    repeat (8) step(1'b0);
    exp_ab = '{-1, 0, 0, -1, 1, 1, 1, 1};
    for (int k = 0; k < 8; k++) chk($sformatf("abort_seq%0d", k), alog[k], exp_ab[k]);
    chk("abort_words", wlog.size(), 6);
    drain(10);

    // Random traffic, random wfull, occasional aborts and mid-run resets.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_req[i] && $urandom_range(0, 3) == 0)
          load(i, $urandom_range(1, 9), DW'($urandom));
        else if (p_req[i] && $urandom_range(0, 39) == 0) begin
          p_req[i] = 1'b0;
          p_left[i] = 0;
        end
      end
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      step($urandom_range(0, 3) == 0);
      rst_n = 1'b1;
    end
    drain(100);

    // Counter wrap: 65535 words, then two more.
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    load(0, 65537, 16'h0000);
    n = 0;
    while (m_xfer != 65535 && n < 70000) begin
      step(1'b0);
      n++;
    end
    chk("wrap_ffff", xfer_cnt, 16'hFFFF);
    step(1'b0);
    chk("wrap_0000", xfer_cnt, 16'h0000);
    step(1'b0);
    chk("wrap_0001", xfer_cnt, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
